capture_sequencer: RTL and testbench

- Sequences one-shot frame capture into the camera image buffer; sits between the SPI command decoder and the cropped pixel stream / image buffer, all in the pixel clock domain.
- Arms on a capture request, waits for a clean frame start and writes exactly one frame's pixels into the buffer.
- Then exposes a byte-by-byte read pointer and a bytes-remaining count to the SPI side.
- Reports timeout, short-frame and long-frame errors.

---
 rtl/capture_sequencer_if.sv | 52 +++++
 rtl/capture_sequencer.sv | 174 +++++++++++++++++
 tb/tb_capture_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/capture_sequencer_if.sv
// -----------------------------------------------------------------------------
// capture_sequencer_if
// Bundles the command, cropped-pixel, image-buffer and SPI read-side signals of
// the capture sequencer.
//   slave  : the sequencer itself (consumes commands/pixels, drives buffer side)
//   master : whoever drives commands and pixels and observes the buffer side
// Signals:
//   capture_request_in  1   pulse, start a capture
//   abort_in            1   pulse, abandon any capture
//   frame_valid_in      1   cropped frame valid
//   line_valid_in       1   cropped line valid
//   pixel_data_in       8   RGB332 pixel
//   read_request_in     1   pulse, consume one captured byte
//   buffer_write_*      1/16/8  image buffer write port
//   buffer_read_address_out 16  read pointer into the image buffer
//   bytes_remaining_out 16  captured bytes not yet read (READY only)
//   capture_busy_out    1   ARMED or CAPTURING
//   capture_done_out    1   READY
//   error_out           2   0 none, 1 arm timeout, 2 short frame, 3 long frame
// -----------------------------------------------------------------------------
interface capture_sequencer_if;
    logic        capture_request_in;
    logic        abort_in;
    logic        frame_valid_in;
    logic        line_valid_in;
    logic [7:0]  pixel_data_in;
    logic        read_request_in;
    logic        buffer_write_enable_out;
    logic [15:0] buffer_write_address_out;
    logic [7:0]  buffer_write_data_out;
    logic [15:0] buffer_read_address_out;
    logic [15:0] bytes_remaining_out;
    logic        capture_busy_out;
    logic        capture_done_out;
    logic [1:0]  error_out;

    modport slave (
        input  capture_request_in, abort_in, frame_valid_in, line_valid_in,
               pixel_data_in, read_request_in,
        output buffer_write_enable_out, buffer_write_address_out,
               buffer_write_data_out, buffer_read_address_out,
               bytes_remaining_out, capture_busy_out, capture_done_out, error_out
    );

    modport master (
        output capture_request_in, abort_in, frame_valid_in, line_valid_in,
               pixel_data_in, read_request_in,
        input  buffer_write_enable_out, buffer_write_address_out,
               buffer_write_data_out, buffer_read_address_out,
               bytes_remaining_out, capture_busy_out, capture_done_out, error_out
    );
endinterface

// File: rtl/capture_sequencer.sv
// -----------------------------------------------------------------------------
// capture_sequencer
// One-shot frame capture into the camera image buffer. Arms on a capture
// request, waits for a clean rising edge of frame valid, writes exactly one
// frame of pixels (registered, 1-cycle latency) and then exposes a read
// pointer plus bytes-remaining count to the SPI side.
// Ports:
//   clock_in  pixel clock, all logic on the rising edge
//   reset_in  synchronous active-high reset
//   bus       capture_sequencer_if.slave (commands, pixels, buffer, status)
// -----------------------------------------------------------------------------
module capture_sequencer #(
    parameter int unsigned CAPTURE_X_RESOLUTION = 200,
    parameter int unsigned CAPTURE_Y_RESOLUTION = 200,
    parameter int unsigned ARM_TIMEOUT_CYCLES   = 2000000
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    capture_sequencer_if.slave    bus
);
    localparam int unsigned CAPTURE_SIZE = CAPTURE_X_RESOLUTION * CAPTURE_Y_RESOLUTION;
    localparam int unsigned TW = (ARM_TIMEOUT_CYCLES > 1) ? $clog2(ARM_TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ARM_TIMEOUT_CYCLES - 1);
    localparam logic [15:0]   SIZE16       = 16'(CAPTURE_SIZE);

    if (CAPTURE_SIZE > 65535 || CAPTURE_SIZE == 0) begin : g_bad_size
        $error("capture_sequencer: CAPTURE_X_RESOLUTION*CAPTURE_Y_RESOLUTION must be 1..65535");
    end
    if (ARM_TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("capture_sequencer: ARM_TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURING, S_READY} state_t;

    state_t          state_q, state_d;
    logic            frame_valid_q;
    logic [15:0]     write_count_q, write_count_d;
    logic [15:0]     read_pointer_q, read_pointer_d;
    logic [TW-1:0]   timeout_q, timeout_d;
    logic            long_q, long_d;
    logic [1:0]      error_q, error_d;
    logic            write_enable_q, write_enable_d;
    logic [15:0]     write_address_q, write_address_d;
    logic [7:0]      write_data_q, write_data_d;

    logic            frame_rise;
    logic            frame_fall;
    logic            pixel_valid;
    logic [15:0]     remaining;

    assign frame_rise  = bus.frame_valid_in & ~frame_valid_q;
    assign frame_fall  = ~bus.frame_valid_in & frame_valid_q;
    assign pixel_valid = bus.frame_valid_in & bus.line_valid_in;
    assign remaining   = write_count_q - read_pointer_q;

    always_comb begin
        state_d         = state_q;
        write_count_d   = write_count_q;
        read_pointer_d  = read_pointer_q;
        timeout_d       = timeout_q;
        long_d          = long_q;
        error_d         = error_q;
        write_enable_d  = 1'b0;
        write_address_d = write_address_q;
        write_data_d    = write_data_q;

        case (state_q)
            S_IDLE: begin
                if (bus.capture_request_in) begin
                    state_d        = S_ARMED;
                    write_count_d  = '0;
                    read_pointer_d = '0;
                    timeout_d      = '0;
                    long_d         = 1'b0;
                    error_d        = 2'd0;
                end
            end
            S_ARMED: begin
                // Only a fresh rising edge starts a capture, so a frame that
                // was already running when we armed is skipped entirely.
                if (frame_rise) begin
                    state_d = S_CAPTURING;
                end else if (timeout_q == TIMEOUT_LAST) begin
                    state_d   = S_IDLE;
                    timeout_d = '0;
                    error_d   = 2'd1;
                end else begin
                    timeout_d = timeout_q + 1'b1;
                end
            end
            S_CAPTURING: begin
                if (frame_fall) begin
                    state_d = S_READY;
                    if (long_q)
                        error_d = 2'd3;
                    else if (write_count_q < SIZE16)
                        error_d = 2'd2;
                    else
                        error_d = 2'd0;
                end else if (pixel_valid) begin
                    if (write_count_q < SIZE16) begin
                        write_enable_d  = 1'b1;
                        write_address_d = write_count_q;
                        write_data_d    = bus.pixel_data_in;
                        write_count_d   = write_count_q + 16'd1;
                    end else begin
                        long_d = 1'b1;
                    end
                end
            end
            S_READY: begin
                if (bus.capture_request_in) begin
                    state_d        = S_ARMED;
                    write_count_d  = '0;
                    read_pointer_d = '0;
                    timeout_d      = '0;
                    long_d         = 1'b0;
                    error_d        = 2'd0;
                end else if (bus.read_request_in && remaining != 16'd0) begin
                    read_pointer_d = read_pointer_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything above, including a same-cycle capture
        // request; the error code is deliberately left as it was.
        if (bus.abort_in) begin
            state_d        = S_IDLE;
            write_enable_d = 1'b0;
            write_count_d  = '0;
            read_pointer_d = '0;
            timeout_d      = '0;
            long_d         = 1'b0;
            error_d        = error_q;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q         <= S_IDLE;
            frame_valid_q   <= 1'b0;
            write_count_q   <= '0;
            read_pointer_q  <= '0;
            timeout_q       <= '0;
            long_q          <= 1'b0;
            error_q         <= 2'd0;
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_data_q    <= '0;
        end else begin
            state_q         <= state_d;
            frame_valid_q   <= bus.frame_valid_in;
            write_count_q   <= write_count_d;
            read_pointer_q  <= read_pointer_d;
            timeout_q       <= timeout_d;
            long_q          <= long_d;
            error_q         <= error_d;
            write_enable_q  <= write_enable_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
        end
    end

    assign bus.buffer_write_enable_out  = write_enable_q;
    assign bus.buffer_write_address_out = write_address_q;
    assign bus.buffer_write_data_out    = write_data_q;
    assign bus.buffer_read_address_out  = read_pointer_q;
    // A partially captured frame is never advertised to the SPI side.
    assign bus.bytes_remaining_out      = (state_q == S_READY) ? remaining : 16'd0;
    assign bus.capture_busy_out         = (state_q == S_ARMED) || (state_q == S_CAPTURING);
    assign bus.capture_done_out         = (state_q == S_READY);
    assign bus.error_out                = error_q;
endmodule

// File: tb/tb_capture_sequencer.sv
// -----------------------------------------------------------------------------
// tb_capture_sequencer
// Directed bench for capture_sequencer with a 4x2 frame (8 bytes) and a
// 16-cycle arm timeout. One task per scenario, each with inline checks.
// -----------------------------------------------------------------------------
module tb_capture_sequencer;
    localparam int X = 4;
    localparam int Y = 2;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   wr_count = 0;

    always #5 clk = ~clk;

    capture_sequencer_if bus ();

    capture_sequencer #(
        .CAPTURE_X_RESOLUTION(X),
        .CAPTURE_Y_RESOLUTION(Y),
        .ARM_TIMEOUT_CYCLES(T)
    ) dut (
        .clock_in(clk),
        .reset_in(rst),
        .bus(bus)
    );

    // Counts every buffer write strobe the design issues.
    always @(negedge clk) begin
        if (bus.buffer_write_enable_out === 1'b1) wr_count++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_capture();
        bus.capture_request_in = 1'b1;
        step();
        bus.capture_request_in = 1'b0;
    endtask

    // Sends a frame of npix pixels in lines of X, then drops frame valid.
    task automatic send_frame(input int npix, input logic [7:0] base, input bit chk);
        int idx = 0;
        logic [7:0] pix;
        bus.frame_valid_in = 1'b1;
        step();
        while (idx < npix) begin
            bus.line_valid_in = 1'b1;
            for (int p = 0; p < X && idx < npix; p++) begin
                pix = base + 8'(idx);
                bus.pixel_data_in = pix;
                step();
                if (chk) begin
                    n_checks++;
                    if (bus.buffer_write_enable_out !== 1'b1 || bus.buffer_write_address_out !== 16'(idx) || bus.buffer_write_data_out !== pix) begin
                        n_fail++;
                        $display("FAIL write%0d: got we=%0b addr=%0d data=%02h expected we=1 addr=%0d data=%02h",
                                 idx, bus.buffer_write_enable_out, bus.buffer_write_address_out, bus.buffer_write_data_out, idx, pix);
                    end
                end
                idx++;
            end
            bus.line_valid_in = 1'b0;
            step();
            if (chk) begin
                n_checks++;
                if (bus.buffer_write_enable_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL line_gap_we: got %0b expected 0", bus.buffer_write_enable_out);
                end
            end
        end
        bus.frame_valid_in = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        n_checks++;
        if ({bus.buffer_write_enable_out, bus.buffer_write_address_out, bus.buffer_write_data_out,
             bus.buffer_read_address_out, bus.bytes_remaining_out, bus.capture_busy_out,
             bus.capture_done_out, bus.error_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b err=%0d rem=%0d raddr=%0d expected all 0",
                     bus.capture_busy_out, bus.capture_done_out, bus.error_out, bus.bytes_remaining_out, bus.buffer_read_address_out);
        end
        $display("reset: outputs after reset checked");
    endtask

    task automatic test_basic_capture();
        int w0 = wr_count;
        pulse_capture();
        n_checks++;
        if (bus.capture_busy_out !== 1'b1) begin n_fail++; $display("FAIL armed_busy: got %0b expected 1", bus.capture_busy_out); end
        step(); step();
        send_frame(8, 8'h10, 1'b1);
        n_checks++;
        if (bus.capture_done_out !== 1'b1 || bus.capture_busy_out !== 1'b0) begin
            n_fail++; $display("FAIL basic_done: got done=%0b busy=%0b expected done=1 busy=0", bus.capture_done_out, bus.capture_busy_out);
        end
        n_checks++;
        if (bus.bytes_remaining_out !== 16'd8 || bus.error_out !== 2'd0) begin
            n_fail++; $display("FAIL basic_status: got rem=%0d err=%0d expected rem=8 err=0", bus.bytes_remaining_out, bus.error_out);
        end
        n_checks++;
        if (wr_count - w0 !== 8) begin n_fail++; $display("FAIL basic_writes: got %0d expected 8", wr_count - w0); end
        $display("basic: 8-pixel frame captured, rem=%0d err=%0d", bus.bytes_remaining_out, bus.error_out);
    endtask

    task automatic test_read();
        bus.read_request_in = 1'b1;
        repeat (3) step();
        bus.read_request_in = 1'b0;
        n_checks++;
        if (bus.buffer_read_address_out !== 16'd3 || bus.bytes_remaining_out !== 16'd5) begin
            n_fail++; $display("FAIL read3: got addr=%0d rem=%0d expected addr=3 rem=5", bus.buffer_read_address_out, bus.bytes_remaining_out);
        end
        bus.read_request_in = 1'b1;
        repeat (6) step();
        bus.read_request_in = 1'b0;
        n_checks++;
        if (bus.buffer_read_address_out !== 16'd8 || bus.bytes_remaining_out !== 16'd0) begin
            n_fail++; $display("FAIL read_nowrap: got addr=%0d rem=%0d expected addr=8 rem=0", bus.buffer_read_address_out, bus.bytes_remaining_out);
        end
        $display("read: pointer=%0d remaining=%0d", bus.buffer_read_address_out, bus.bytes_remaining_out);
    endtask

    task automatic test_mid_frame_arm();
        int w0;
        bus.frame_valid_in = 1'b1;
        bus.line_valid_in  = 1'b1;
        bus.pixel_data_in  = 8'hAA;
        step(); step();
        w0 = wr_count;
        pulse_capture();
        repeat (3) step();
        bus.frame_valid_in = 1'b0;
        bus.line_valid_in  = 1'b0;
        step(); step();
        n_checks++;
        if (wr_count !== w0 || bus.capture_busy_out !== 1'b1) begin
            n_fail++; $display("FAIL midframe_skip: got writes=%0d busy=%0b expected writes=0 busy=1", wr_count - w0, bus.capture_busy_out);
        end
        send_frame(8, 8'h40, 1'b1);
        n_checks++;
        if (bus.capture_done_out !== 1'b1 || bus.bytes_remaining_out !== 16'd8 || wr_count - w0 !== 8) begin
            n_fail++; $display("FAIL midframe_next: got done=%0b rem=%0d writes=%0d expected done=1 rem=8 writes=8",
                               bus.capture_done_out, bus.bytes_remaining_out, wr_count - w0);
        end
        $display("midframe: armed during frame, next frame captured rem=%0d", bus.bytes_remaining_out);
    endtask

    task automatic test_timeout();
        pulse_capture();
        repeat (T - 1) step();
        n_checks++;
        if (bus.capture_busy_out !== 1'b1) begin n_fail++; $display("FAIL timeout_early: got busy=%0b expected 1", bus.capture_busy_out); end
        step();
        n_checks++;
        if (bus.capture_busy_out !== 1'b0 || bus.capture_done_out !== 1'b0 || bus.error_out !== 2'd1) begin
            n_fail++; $display("FAIL timeout: got busy=%0b done=%0b err=%0d expected busy=0 done=0 err=1",
                               bus.capture_busy_out, bus.capture_done_out, bus.error_out);
        end
        $display("timeout: err=%0d busy=%0b", bus.error_out, bus.capture_busy_out);
    endtask

    task automatic test_short_long();
        int w0 = wr_count;
        pulse_capture();
        send_frame(6, 8'h60, 1'b0);
        n_checks++;
        if (bus.capture_done_out !== 1'b1 || bus.bytes_remaining_out !== 16'd6 || bus.error_out !== 2'd2 || wr_count - w0 !== 6) begin
            n_fail++; $display("FAIL short: got done=%0b rem=%0d err=%0d writes=%0d expected done=1 rem=6 err=2 writes=6",
                               bus.capture_done_out, bus.bytes_remaining_out, bus.error_out, wr_count - w0);
        end
        $display("short: rem=%0d err=%0d", bus.bytes_remaining_out, bus.error_out);
        w0 = wr_count;
        pulse_capture();
        send_frame(10, 8'h80, 1'b0);
        n_checks++;
        if (bus.capture_done_out !== 1'b1 || bus.bytes_remaining_out !== 16'd8 || bus.error_out !== 2'd3 || wr_count - w0 !== 8) begin
            n_fail++; $display("FAIL long: got done=%0b rem=%0d err=%0d writes=%0d expected done=1 rem=8 err=3 writes=8",
                               bus.capture_done_out, bus.bytes_remaining_out, bus.error_out, wr_count - w0);
        end
        $display("long: rem=%0d err=%0d", bus.bytes_remaining_out, bus.error_out);
    endtask

    task automatic test_abort();
        int w0;
        // Abort from READY keeps the error code but clears the pointer.
        bus.read_request_in = 1'b1;
        step();
        bus.read_request_in = 1'b0;
        bus.abort_in = 1'b1;
        step();
        bus.abort_in = 1'b0;
        n_checks++;
        if (bus.capture_done_out !== 1'b0 || bus.error_out !== 2'd3 || bus.buffer_read_address_out !== 16'd0) begin
            n_fail++; $display("FAIL abort_ready: got done=%0b err=%0d raddr=%0d expected done=0 err=3 raddr=0",
                               bus.capture_done_out, bus.error_out, bus.buffer_read_address_out);
        end
        // Abort on the 3rd pixel of a frame.
        w0 = wr_count;
        pulse_capture();
        bus.frame_valid_in = 1'b1;
        step();
        bus.line_valid_in = 1'b1;
        for (int p = 0; p < 6; p++) begin
            bus.pixel_data_in = 8'hC0 + 8'(p);
            bus.abort_in = (p == 2);
            step();
        end
        bus.abort_in = 1'b0;
        bus.line_valid_in = 1'b0;
        bus.frame_valid_in = 1'b0;
        step(); step();
        n_checks++;
        if (wr_count - w0 !== 2 || bus.capture_busy_out !== 1'b0 || bus.capture_done_out !== 1'b0 || bus.bytes_remaining_out !== 16'd0) begin
            n_fail++; $display("FAIL abort_capture: got writes=%0d busy=%0b done=%0b rem=%0d expected writes=2 busy=0 done=0 rem=0",
                               wr_count - w0, bus.capture_busy_out, bus.capture_done_out, bus.bytes_remaining_out);
        end
        // Read requests in IDLE do nothing.
        bus.read_request_in = 1'b1;
        step();
        bus.read_request_in = 1'b0;
        n_checks++;
        if (bus.buffer_read_address_out !== 16'd0) begin n_fail++; $display("FAIL idle_read: got %0d expected 0", bus.buffer_read_address_out); end
        // Abort beats a simultaneous capture request.
        bus.capture_request_in = 1'b1;
        bus.abort_in = 1'b1;
        step();
        bus.capture_request_in = 1'b0;
        bus.abort_in = 1'b0;
        step();
        n_checks++;
        if (bus.capture_busy_out !== 1'b0) begin n_fail++; $display("FAIL abort_wins: got busy=%0b expected 0", bus.capture_busy_out); end
        $display("abort: writes before abort=%0d busy=%0b", wr_count - w0, bus.capture_busy_out);
    endtask

    task automatic test_reset_mid_capture();
        pulse_capture();
        bus.frame_valid_in = 1'b1;
        step();
        bus.line_valid_in = 1'b1;
        bus.pixel_data_in = 8'h55;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.line_valid_in = 1'b0;
        bus.frame_valid_in = 1'b0;
        n_checks++;
        if (bus.capture_busy_out !== 1'b0 || bus.error_out !== 2'd0 || bus.buffer_write_enable_out !== 1'b0 || bus.bytes_remaining_out !== 16'd0) begin
            n_fail++; $display("FAIL reset_mid: got busy=%0b err=%0d we=%0b rem=%0d expected all 0",
                               bus.capture_busy_out, bus.error_out, bus.buffer_write_enable_out, bus.bytes_remaining_out);
        end
        $display("reset_mid: busy=%0b err=%0d", bus.capture_busy_out, bus.error_out);
    endtask

    initial begin
        bus.capture_request_in = 1'b0;
        bus.abort_in           = 1'b0;
        bus.frame_valid_in     = 1'b0;
        bus.line_valid_in      = 1'b0;
        bus.pixel_data_in      = 8'h00;
        bus.read_request_in    = 1'b0;
        test_reset();
        test_basic_capture();
        test_read();
        test_mid_frame_arm();
        test_timeout();
        test_short_long();
        test_abort();
        test_reset_mid_capture();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
